// File: rtl/png_pixel_scheduler.sv
// Two-source round-robin byte scheduler feeding a shared PNG pixel converter.
// A grant covers one BURST-byte pixel group and is never preempted.
module png_pixel_scheduler #(
    parameter int BURST = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    output logic       s1_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_src,
    output logic       m_first,
    output logic       busy,
    output logic       dbg_state
);

    // Handshake: a byte moves on any rising edge where valid and ready are
    // both high; valid must not depend on ready, ready may depend on valid.

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [3:0] LAST = 4'(BURST - 1);

    state_t     state;
    logic       grant;
    logic       last_grant;
    logic [3:0] cnt;

    logic       take;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       xfer;

    assign dbg_state = (state == XFER);

    // The output register can accept a byte when empty or draining this cycle.
    always_comb begin
        take      = !m_valid || m_ready;
        sel_valid = grant ? s1_valid : s0_valid;
        sel_data  = grant ? s1_data  : s0_data;
        s0_ready  = (state == XFER) && !grant && take;
        s1_ready  = (state == XFER) &&  grant && take;
        xfer      = (state == XFER) && sel_valid && take;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            m_data     <= 8'h00;
            m_valid    <= 1'b0;
            m_src      <= 1'b0;
            m_first    <= 1'b0;
        end else begin
            if (xfer) begin
                m_data  <= sel_data;
                m_valid <= 1'b1;
                m_src   <= grant;
                m_first <= (cnt == 4'd0);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (s0_valid && s1_valid) begin
                        grant <= !last_grant;
                        state <= XFER;
                        busy  <= 1'b1;
                    end else if (s0_valid) begin
                        grant <= 1'b0;
                        state <= XFER;
                        busy  <= 1'b1;
                    end else if (s1_valid) begin
                        grant <= 1'b1;
                        state <= XFER;
                        busy  <= 1'b1;
                    end
                end
                XFER: begin
                    if (xfer) begin
                        if (cnt == LAST) begin
                            cnt        <= 4'd0;
                            last_grant <= grant;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_png_pixel_scheduler.sv
// Scoreboard bench for png_pixel_scheduler: a BURST=3 instance under directed
// scenarios and a BURST=1 instance with both sources always valid.
module tb_png_pixel_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
    logic       s0_valid = 1'b0, s1_valid = 1'b0;
    logic       s0_ready, s1_ready;
    logic [7:0] m_data;
    logic       m_valid, m_src, m_first, busy, dbg_state;
    logic       m_ready = 1'b1;

    logic [7:0] b1_m_data;
    logic       b1_s0_ready, b1_s1_ready, b1_m_valid, b1_m_src, b1_m_first, b1_busy, b1_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src0_q[$];
    logic [7:0] src1_q[$];
    logic [9:0] exp_q[$];
    logic       hs0 = 1'b0, hs1 = 1'b0;

    logic       b1_exp_src = 1'b0;
    int         b1_cnt = 0;

    always #5 clk = ~clk;

    png_pixel_scheduler #(.BURST(3)) u_dut (
        .clk(clk), .rst(rst),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_src(m_src), .m_first(m_first), .busy(busy), .dbg_state(dbg_state)
    );

    png_pixel_scheduler #(.BURST(1)) u_dut_b1 (
        .clk(clk), .rst(rst),
        .s0_data(8'h0A), .s0_valid(1'b1), .s0_ready(b1_s0_ready),
        .s1_data(8'h1B), .s1_valid(1'b1), .s1_ready(b1_s1_ready),
        .m_data(b1_m_data), .m_valid(b1_m_valid), .m_ready(1'b1),
        .m_src(b1_m_src), .m_first(b1_m_first), .busy(b1_busy), .dbg_state(b1_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic src_push(input bit src, input logic [7:0] d);
        if (src) src1_q.push_back(d);
        else     src0_q.push_back(d);
    endtask

    task automatic exp_push(input bit src, input bit first, input logic [7:0] d);
        exp_q.push_back({src, first, d});
    endtask

    // Source drivers: handshakes are sampled mid-cycle, queues advance after the edge.
    always @(negedge clk) begin
        hs0 = s0_valid && s0_ready;
        hs1 = s1_valid && s1_ready;
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            src0_q.delete();
            src1_q.delete();
        end else begin
            if (hs0 && src0_q.size() > 0) void'(src0_q.pop_front());
            if (hs1 && src1_q.size() > 0) void'(src1_q.pop_front());
        end
        s0_valid = (src0_q.size() > 0);
        s0_data  = s0_valid ? src0_q[0] : 8'h00;
        s1_valid = (src1_q.size() > 0);
        s1_data  = s1_valid ? src1_q[0] : 8'h00;
    end

    // Output monitor for the BURST=3 instance.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
            else check("out", 32'({m_src, m_first, m_data}), 32'(exp_q.pop_front()));
        end
    end

    // BURST=1 instance: every byte opens a group and sources alternate.
    always @(negedge clk) begin
        if (rst) begin
            b1_exp_src = 1'b0;
        end else if (b1_m_valid) begin
            check("b1_first", 32'(b1_m_first), 32'd1);
            check("b1_src", 32'(b1_m_src), 32'(b1_exp_src));
            check("b1_data", 32'(b1_m_data), b1_exp_src ? 32'h1B : 32'h0A);
            b1_exp_src = !b1_exp_src;
            b1_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = busy;
        end
        if (!seen) check(tag, 32'(busy), 32'd1);
    endtask

    task automatic wait_mvalid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid;
        end
        if (!seen) check(tag, 32'(m_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy && !m_valid;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [14:0] pat;

        // Reset values
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'h00);
        check("rst_m_src", 32'(m_src), 32'd0);
        check("rst_m_first", 32'(m_first), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_ready", 32'({s0_ready, s1_ready}), 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        // Single source, one group
        @(posedge clk); #2;
        src_push(0, 8'h11); src_push(0, 8'h22); src_push(0, 8'h33);
        exp_push(0, 1, 8'h11); exp_push(0, 0, 8'h22); exp_push(0, 0, 8'h33);
        @(negedge clk);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_ready", 32'({s0_ready, s1_ready}), 32'd0);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'({s0_ready, s1_ready}), 32'b10);
        @(negedge clk);
        check("t1_byte0_valid", 32'(m_valid), 32'd1);
        @(negedge clk);
        check("t1_byte1_valid", 32'(m_valid), 32'd1);
        @(negedge clk);
        check("t1_byte2_valid", 32'({m_valid, busy}), 32'b10);
        @(negedge clk);
        check("t1_drained", 32'(m_valid), 32'd0);
        wait_idle("t1_idle");

        // Both sources continuously valid: alternation with one-cycle bubbles
        do_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 3; i++) exp_push(0, i == 0, 8'(8'h40 + 3*g + i));
            for (int i = 0; i < 3; i++) exp_push(1, i == 0, 8'(8'h80 + 3*g + i));
        end
        for (int i = 0; i < 6; i++) begin
            src_push(0, 8'(8'h40 + i));
            src_push(1, 8'(8'h80 + i));
        end
        wait_mvalid("t2_first_timeout");
        pat = '0;
        pat[14] = m_valid;
        for (int i = 13; i >= 0; i--) begin
            @(negedge clk);
            pat[i] = m_valid;
        end
        check("t2_bubble", 32'(pat), 32'(15'b111011101110111));
        wait_idle("t2_idle");

        // Output stall for 4 cycles after the first byte
        do_reset();
        m_ready = 1'b0;
        src_push(0, 8'hA5); src_push(0, 8'hB6); src_push(0, 8'hC7);
        exp_push(0, 1, 8'hA5); exp_push(0, 0, 8'hB6); exp_push(0, 0, 8'hC7);
        wait_mvalid("t3_first_timeout");
        for (int i = 0; i < 4; i++) begin
            check("t3_hold", 32'({m_valid, m_first, m_data}), 32'({1'b1, 1'b1, 8'hA5}));
            check("t3_s0_ready", 32'(s0_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #2 m_ready = 1'b1;
        wait_idle("t3_idle");

        // Granted s1 stalls after one byte while s0 waits; no preemption
        exp_push(1, 1, 8'h61); exp_push(1, 0, 8'h62); exp_push(1, 0, 8'h63);
        exp_push(0, 1, 8'h71); exp_push(0, 0, 8'h72); exp_push(0, 0, 8'h73);
        @(posedge clk); #2 src_push(1, 8'h61);
        wait_busy("t4_busy_timeout");
        @(posedge clk); #2;
        src_push(0, 8'h71); src_push(0, 8'h72); src_push(0, 8'h73);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_busy", 32'(busy), 32'd1);
            check("t4_s0_ready", 32'(s0_ready), 32'd0);
        end
        @(posedge clk); #2;
        src_push(1, 8'h62); src_push(1, 8'h63);
        wait_idle("t4_idle");

        // Reset mid-group, then fresh arbitration
        @(posedge clk); #2;
        src_push(0, 8'hE1); src_push(0, 8'hE2); src_push(0, 8'hE3);
        exp_push(0, 1, 8'hE1);
        wait_mvalid("t5_first_timeout");
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_rst_out", 32'({m_valid, m_src, m_first, m_data}), 32'd0);
        check("t5_rst_busy", 32'({busy, s0_ready, s1_ready}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            src_push(0, 8'(8'hF0 + i));
            src_push(1, 8'(8'hF8 + i));
        end
        for (int i = 0; i < 3; i++) exp_push(0, i == 0, 8'(8'hF0 + i));
        for (int i = 0; i < 3; i++) exp_push(1, i == 0, 8'(8'hF8 + i));
        wait_idle("t5_idle");

        check("b1_count", 32'(b1_cnt >= 8), 32'd1);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
